// File: rtl/priority_arbiter_7seg_if.sv
// Request/grant bundle for priority_arbiter_7seg: the requester side (master) drives req,
// and the arbiter side (slave) drives the grant and display outputs.
interface priority_arbiter_7seg_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;
  logic [6:0] segments;
  logic       none;

  modport master (
    output req,
    input  gnt, gnt_valid, gnt_idx, timeout, segments, none
  );

  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_idx, timeout, segments, none
  );
endinterface

// File: rtl/priority_arbiter_7seg.sv
// 8-requester hold-until-release arbiter with a 7-segment readout of the granted index.
// Define ARB_ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority (bit 7 wins).
module priority_arbiter_7seg #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_arbiter_7seg_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_r;
  logic [7:0]       gnt_r;
  logic             gnt_valid_r;
  logic [2:0]       gnt_idx_r;
  logic [6:0]       segments_r;
  logic             none_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       winner_s;
  logic             release_s;
  logic             at_limit_s;
  logic             timeout_s;
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0]       rr_ptr_r;
`endif

  function automatic logic [6:0] seg_of(input logic [2:0] idx);
    logic [6:0] s;
    case (idx)
      3'd0:    s = 7'b0111111;
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1011011;
      3'd3:    s = 7'b1001111;
      3'd4:    s = 7'b1100110;
      3'd5:    s = 7'b1101101;
      3'd6:    s = 7'b1111101;
      3'd7:    s = 7'b0000111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] pick_fixed(input logic [7:0] r);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) begin
        w = 3'(i);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // The pointer holds the last winner: the search starts just below it and visits it last.
  function automatic logic [2:0] pick_rr(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] w;
    logic [2:0] k;
    logic       found;
    w     = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      k = last - 3'(i);
      if (!found && r[k]) begin
        w     = k;
        found = 1'b1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Winner selection and grant-exit conditions
  always_comb begin
    winner_s   = 3'd0;
`ifdef ARB_ROUND_ROBIN_EN
    winner_s   = pick_rr(bus.req, rr_ptr_r);
`else
    winner_s   = pick_fixed(bus.req);
`endif
    release_s  = ~bus.req[gnt_idx_r];
    at_limit_s = (cnt_r == HOLD_LAST);
    timeout_s  = (state_r == GRANT) && at_limit_s && !release_s;
  end

  // Arbiter FSM with registered grant and display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= 8'h00;
      gnt_valid_r <= 1'b0;
      gnt_idx_r   <= 3'd0;
      segments_r  <= 7'b0000000;
      none_r      <= 1'b1;
      cnt_r       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_r    <= 3'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req != 8'h00) begin
            state_r     <= GRANT;
            gnt_r       <= 8'b0000_0001 << winner_s;
            gnt_valid_r <= 1'b1;
            gnt_idx_r   <= winner_s;
            segments_r  <= seg_of(winner_s);
            none_r      <= 1'b0;
            cnt_r       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_r    <= winner_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (release_s || at_limit_s) begin
            state_r     <= GAP;
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
            gnt_idx_r   <= 3'd0;
            segments_r  <= 7'b0000000;
            none_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= 8'h00;
          gnt_valid_r <= 1'b0;
          gnt_idx_r   <= 3'd0;
          segments_r  <= 7'b0000000;
          none_r      <= 1'b1;
          cnt_r       <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.segments  = segments_r;
  assign bus.none      = none_r;
  // Release beats timeout, and release is judged on this cycle's req, so the pulse is decoded live.
  assign bus.timeout   = timeout_s;

endmodule
